dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the target end of the CPU load/store port.
//  Accepts one word request per cycle over valid/ready, performs the RAM access and returns a registered response over valid/ready.
//  Sits between the CPU LW/SW datapath and a synchronous word RAM.
//  Flags misaligned and out-of-range accesses instead of silently aliasing them.
// PARAMETERS
//  ADDR_W  8   word-address width; RAM depth = 2**ADDR_W words
//  DATA_W  32  word width; only 32 is supported (byte enables assume 4 lanes)
// PORTS
//  CLK        in   1       single clock; all state updates on posedge
//  RST_N      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept this cycle
//  req_we     in   1       1 = store, 0 = load
//  req_addr   in   32      byte address
//  req_wdata  in   DATA_W  store data
//  req_be     in   4       store byte enables; bit i covers bits [8i+7:8i]
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       requester takes response
//  rsp_rdata  out  DATA_W  load data; 0 for stores and errors
//  rsp_err    out  1       access was misaligned or out of range
//  led_out    out  3       MMIO LED register (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, led_out=0. RAM contents are not reset.
//    Reset asserted mid-transaction drops the pending response. No write is performed on the edge where RST_N is low.
//  - Request handshake: accepted on a posedge with req_valid && req_ready.
//    The requester holds all req_* fields stable while req_valid=1 && req_ready=0.
//  - req_ready = !rsp_valid || rsp_ready (combinational). Back-to-back throughput is one request per cycle.
//  - One-stage output register, states EMPTY (rsp_valid=0) and FULL (rsp_valid=1):
//      EMPTY --accept--> FULL
//      FULL  --rsp_ready && !accept--> EMPTY
//      FULL  --rsp_ready && accept--> FULL (new response loaded)
//      FULL  --!rsp_ready--> FULL; rsp_* held stable
//  - Latency: rsp_valid rises exactly one cycle after the accept edge.
//  - Index: idx = req_addr[ADDR_W+1:2].
//  - Error when req_addr[1:0]!=0, or req_addr[31:ADDR_W+2]!=0 (except the MMIO address, if enabled).
//    On error: no RAM/LED write, rsp_err=1, rsp_rdata=0.
//  - Store, no error: at the accept edge, RAM[idx] lanes with req_be=1 take req_wdata; other lanes unchanged.
//    req_be=0 is legal: no-op with a normal response. Response: rdata=0, err=0.
//  - Load, no error: rsp_rdata=RAM[idx] as sampled at the accept edge, err=0.
//    A load accepted the cycle after a store to the same idx returns the new data.
//  - rsp_valid && !rsp_ready with req_valid: the request is stalled, never dropped.
// CONFIGURATION
//  DMEM_MMIO_LED_EN defined:
//    Byte address 32'h0000_0400 (word 2**ADDR_W at the default) is the LED register.
//    Store with req_be[0]=1: led_out <= req_wdata[2:0].
//    Load: rdata = {29'b0, led_out}. Never errors.
//  DMEM_MMIO_LED_EN undefined:
//    led_out is tied to 0; 0x400 is out of range and errors.
// STRUCTURE
//  - Package tiny_cpu_pkg:
//      localparam DMEM_LED_ADDR = 32'h400
//      localparam WORD_BYTES = 4
//      typedef enum {RSP_EMPTY, RSP_FULL} for the output stage
//  - Sub-module dmem_ram: synchronous single-port RAM with byte-lane write enables and registered read.
//    Instantiated once. Handshake, error and MMIO logic stay in dmem_responder.
// TESTING
//  1. Reset with rsp_ready=1. Store 0xDEADBEEF @0x004 be=F, then load @0x004.
//     -> Two accepts on consecutive cycles. Responses err=0/rdata=0, then rdata=0xDEADBEEF, each one cycle after its accept.
//  2. Preload 0x11223344 @0x008. Store 0xAABBCCDD be=0101, then load @0x008.
//     -> rdata=0x11BB33DD.
//  3. rsp_ready=0 for 3 cycles with a load pending and a new req_valid.
//     -> rsp_* stable, req_ready=0. New request accepted on the cycle rsp_ready=1; its response one cycle later.
//  4. Load @0x006, and store @0x800.
//     -> Both err=1, rdata=0. RAM word 1 and word 0 unchanged on readback.
//  5. Store 5 @0x400, then load @0x400.
//     -> EN: led_out=3'b101, rdata=5, err=0. Not EN: err=1 for both, led_out=0.
//  6. Assert RST_N low while rsp_valid=1.
//     -> rsp_valid=0, led_out=0 immediately (async). No response after release.

Source files
------------

// File: rtl/tiny_cpu_pkg.sv
// Shared constants and types for the tiny CPU data-memory port.
package tiny_cpu_pkg;

  // Byte address of the memory-mapped LED register.
  localparam logic [31:0] DMEM_LED_ADDR = 32'h0000_0400;

  // Bytes per data word; one byte enable per lane.
  localparam int WORD_BYTES = 4;

  // Occupancy of the single response register.
  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } rsp_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port word RAM with byte-lane write enables and a
// registered read port. The read register only updates on a read access,
// so the last load result stays on rdata_o until the next load.
module dmem_ram
  import tiny_cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write or registered read of the addressed word.
  // NOTE: storage and its read register have no reset; a reset on the array
  // would stop it mapping onto RAM macros, and the contents are don't-care.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the CPU load/store port.
// Accepts one word request per cycle over valid/ready, performs the RAM
// access and returns a one-stage registered response over valid/ready.
// Misaligned and out-of-range addresses are flagged with rsp_err.
// Optional feature: define DMEM_MMIO_LED_EN to map a 3-bit LED register at
// byte address 0x400; otherwise led_out is tied low and 0x400 errors.
module dmem_responder
  import tiny_cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        led_out
);

  rsp_state_e        state_q;
  logic              err_q;
  logic              load_q;
  logic              led_sel_q;
  logic [2:0]        led_rd_q;
  logic [2:0]        led_q;

  logic              accept;
  logic              is_led;
  logic              addr_err;
  logic              ram_en;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] ram_rdata;

  // A new request can enter whenever the response slot is empty or is
  // being drained this cycle.
  assign req_ready = (state_q == RSP_EMPTY) || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[ADDR_W+1:2];

`ifdef DMEM_MMIO_LED_EN
  assign is_led = (req_addr == DMEM_LED_ADDR);
`else
  assign is_led = 1'b0;
`endif

  // The LED address is exempt from the range check; everything else must be
  // word aligned and inside the RAM.
  assign addr_err = !is_led &&
                    ((req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0));

  // RST_N gates the enable so no write lands on an edge held in reset.
  assign ram_en = accept && RST_N && !addr_err && !is_led;

  dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (CLK),
    .en_i    (ram_en),
    .we_i    (req_we),
    .be_i    (req_be),
    .addr_i  (idx),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_MMIO_LED_EN
  // LED register: a store with lane 0 enabled updates the three LED bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_q <= 3'b000;
    end else if (accept && is_led && req_we && req_be[0]) begin
      led_q <= req_wdata[2:0];
    end
  end
`else
  assign led_q = 3'b000;
`endif

  assign led_out = led_q;

  // Response slot: load a new response on accept, otherwise drain on ready;
  // while stalled every field holds so rsp_* stay stable.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= RSP_EMPTY;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      led_sel_q <= 1'b0;
      led_rd_q  <= 3'b000;
    end else if (accept) begin
      state_q   <= RSP_FULL;
      err_q     <= addr_err;
      load_q    <= !req_we && !addr_err;
      led_sel_q <= is_led;
      led_rd_q  <= led_q;
    end else if (rsp_ready) begin
      state_q   <= RSP_EMPTY;
    end
  end

  // Load data comes from the RAM read register or the LED snapshot; stores
  // and errors return zero.
  // NOTE: the default assignment first keeps this purely combinational with
  // no inferred latch on paths that skip the if.
  always_comb begin
    rsp_rdata = '0;
    if (load_q) begin
      rsp_rdata = led_sel_q ? {{(DATA_W-3){1'b0}}, led_rd_q} : ram_rdata;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  led_out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(
    .ADDR_W (8),
    .DATA_W (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .led_out   (led_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
  endtask

  task automatic expect_rsp(input string tag, input logic err, input logic [31:0] rdata);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".err"},   32'(rsp_err),   32'(err));
    check({tag, ".rdata"}, rsp_rdata,      rdata);
  endtask

  initial begin
    idle();
    rsp_ready = 1'b1;
    RST_N     = 1'b0;
    tick();
    tick();
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_rdata", rsp_rdata,      32'd0);
    check("reset.rsp_err",   32'(rsp_err),   32'd0);
    check("reset.led_out",   32'(led_out),   32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    RST_N = 1'b1;
    tick();

    // 1: back-to-back store then load of the same word.
    send(1'b1, 32'h004, 32'hDEAD_BEEF, 4'hF);
    tick();
    expect_rsp("t1.store", 1'b0, 32'h0);
    send(1'b0, 32'h004, 32'h0, 4'h0);
    tick();
    expect_rsp("t1.load", 1'b0, 32'hDEAD_BEEF);
    idle();
    tick();
    check("t1.drained", 32'(rsp_valid), 32'd0);

    // 2: partial byte-lane store over a preloaded word.
    send(1'b1, 32'h008, 32'h1122_3344, 4'hF);
    tick();
    expect_rsp("t2.preload", 1'b0, 32'h0);
    send(1'b1, 32'h008, 32'hAABB_CCDD, 4'b0101);
    tick();
    expect_rsp("t2.store", 1'b0, 32'h0);
    send(1'b0, 32'h008, 32'h0, 4'h0);
    tick();
    expect_rsp("t2.load", 1'b0, 32'h11BB_33DD);
    idle();
    tick();

    // 3: back-pressure holds the response and stalls the next request.
    rsp_ready = 1'b0;
    send(1'b0, 32'h004, 32'h0, 4'h0);
    tick();
    expect_rsp("t3.first", 1'b0, 32'hDEAD_BEEF);
    send(1'b0, 32'h008, 32'h0, 4'h0);
    #1;
    check("t3.ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_rsp("t3.hold", 1'b0, 32'hDEAD_BEEF);
      check("t3.hold.ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("t3.ready_high", 32'(req_ready), 32'd1);
    tick();
    expect_rsp("t3.second", 1'b0, 32'h11BB_33DD);
    idle();
    tick();
    check("t3.drained", 32'(rsp_valid), 32'd0);

    // 4: misaligned and out-of-range accesses error and write nothing.
    send(1'b1, 32'h000, 32'h0BAD_F00D, 4'hF);
    tick();
    expect_rsp("t4.word0", 1'b0, 32'h0);
    send(1'b0, 32'h006, 32'h0, 4'h0);
    tick();
    expect_rsp("t4.mis_load", 1'b1, 32'h0);
    send(1'b1, 32'h005, 32'hFFFF_FFFF, 4'hF);
    tick();
    expect_rsp("t4.mis_store", 1'b1, 32'h0);
    send(1'b1, 32'h800, 32'hFFFF_FFFF, 4'hF);
    tick();
    expect_rsp("t4.oor_store", 1'b1, 32'h0);
    send(1'b0, 32'h004, 32'h0, 4'h0);
    tick();
    expect_rsp("t4.word1", 1'b0, 32'hDEAD_BEEF);
    send(1'b0, 32'h000, 32'h0, 4'h0);
    tick();
    expect_rsp("t4.word0_rb", 1'b0, 32'h0BAD_F00D);
    send(1'b1, 32'h00C, 32'h1234_5678, 4'h0);
    tick();
    expect_rsp("t4.be0_store", 1'b0, 32'h0);
    idle();
    tick();

    // 5: LED register (or out-of-range error when the feature is off).
    send(1'b1, 32'h400, 32'h0000_0005, 4'h1);
    tick();
`ifdef DMEM_MMIO_LED_EN
    expect_rsp("t5.led_store", 1'b0, 32'h0);
    check("t5.led_out", 32'(led_out), 32'd5);
`else
    expect_rsp("t5.led_store", 1'b1, 32'h0);
    check("t5.led_out", 32'(led_out), 32'd0);
`endif
    send(1'b0, 32'h400, 32'h0, 4'h0);
    tick();
`ifdef DMEM_MMIO_LED_EN
    expect_rsp("t5.led_load", 1'b0, 32'h5);
`else
    expect_rsp("t5.led_load", 1'b1, 32'h0);
`endif
    send(1'b0, 32'h000, 32'h0, 4'h0);
    tick();
    expect_rsp("t5.word0_rb", 1'b0, 32'h0BAD_F00D);
    idle();
    tick();

    // 6: asynchronous reset drops a pending response; no write in reset.
    rsp_ready = 1'b0;
    send(1'b0, 32'h004, 32'h0, 4'h0);
    tick();
    check("t6.pending", 32'(rsp_valid), 32'd1);
    send(1'b1, 32'h004, 32'h1234_5678, 4'hF);
    RST_N = 1'b0;
    #1;
    check("t6.async_valid", 32'(rsp_valid), 32'd0);
    check("t6.async_led",   32'(led_out),   32'd0);
    check("t6.async_err",   32'(rsp_err),   32'd0);
    tick();
    idle();
    RST_N     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    check("t6.no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("t6.no_rsp2", 32'(rsp_valid), 32'd0);
    send(1'b0, 32'h004, 32'h0, 4'h0);
    tick();
    expect_rsp("t6.word1_rb", 1'b0, 32'hDEAD_BEEF);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
